// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select, IF/ID pipeline register and BOOT/RUN/HALT control.
// Define FETCH_PERF_CNT_EN to add the FetchCount/FlushCount performance counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        Halt,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] JumpTarget,
   input  logic [31:0] JrTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] Address,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] FetchCount,
   output logic [31:0] FlushCount,
`endif
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PCPlus4,
   output logic        IF_ID_Valid
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_p0, pc_nxt, pc_plus4;
   logic [31:0] instr_nxt, pc4_nxt;
   logic        vld_nxt;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h3;
   endfunction

   assign pc_plus4 = pc_p0 + 32'd4;
   assign Address  = word_align(pc_p0);

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_p0;
      instr_nxt = IF_ID_Instruction;
      pc4_nxt   = IF_ID_PCPlus4;
      vld_nxt   = IF_ID_Valid;
      case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            if (Halt) begin
               state_nxt = HALT;
               instr_nxt = 32'h0;
               pc4_nxt   = 32'h0;
               vld_nxt   = 1'b0;
            end else begin
               // redirects win over stall so a resolved branch is never lost
               case (PCSrc)
                  2'd1:    pc_nxt = word_align(BranchTarget);
                  2'd2:    pc_nxt = word_align(JumpTarget);
                  2'd3:    pc_nxt = word_align(JrTarget);
                  default: pc_nxt = Stall ? pc_p0 : word_align(pc_plus4);
               endcase
               if (Flush) begin
                  instr_nxt = 32'h0;
                  pc4_nxt   = 32'h0;
                  vld_nxt   = 1'b0;
               end else if (!Stall) begin
                  instr_nxt = Instruction;
                  pc4_nxt   = pc_plus4;
                  vld_nxt   = 1'b1;
               end
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = BOOT;
      endcase
   end

   // PC and IF/ID register boundary
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state             <= BOOT;
         pc_p0             <= RESET_PC;
         IF_ID_Instruction <= 32'h0;
         IF_ID_PCPlus4     <= 32'h0;
         IF_ID_Valid       <= 1'b0;
      end else begin
         state             <= state_nxt;
         pc_p0             <= pc_nxt;
         IF_ID_Instruction <= instr_nxt;
         IF_ID_PCPlus4     <= pc4_nxt;
         IF_ID_Valid       <= vld_nxt;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic fetch_inc, flush_inc;

   assign fetch_inc = (state == RUN) && !Halt && !Flush && !Stall;
   assign flush_inc = (state == RUN) && Flush;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         FetchCount <= 32'h0;
         FlushCount <= 32'h0;
      end else begin
         if (fetch_inc) FetchCount <= FetchCount + 32'd1;
         if (flush_inc) FlushCount <= FlushCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus hand sequences for reset, halt and counters.
// Instruction memory is modelled as mem[i] = i*4, i.e. the read data equals the word address.
module tb_fetch_stage;

   logic        Clk = 1'b0;
   logic        Reset, Stall, Flush, Halt;
   logic [1:0]  PCSrc;
   logic [31:0] BranchTarget, JumpTarget, JrTarget, Instruction, Address;
   logic [31:0] IF_ID_Instruction, IF_ID_PCPlus4;
   logic        IF_ID_Valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] FetchCount, FlushCount;
`endif

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;
   assign Instruction = Address;

   fetch_stage dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Halt(Halt),
      .PCSrc(PCSrc), .BranchTarget(BranchTarget), .JumpTarget(JumpTarget),
      .JrTarget(JrTarget), .Instruction(Instruction), .Address(Address),
`ifdef FETCH_PERF_CNT_EN
      .FetchCount(FetchCount), .FlushCount(FlushCount),
`endif
      .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
      .IF_ID_Valid(IF_ID_Valid)
   );

   typedef struct packed {
      logic        s, f, h;
      logic [1:0]  p;
      logic [31:0] b, j, r;
      logic [31:0] epc, ei, ep4;
      logic        ev;
   } vec_t;

   function automatic vec_t mk(input logic s, f, h, input logic [1:0] p,
                               input logic [31:0] b, j, r, epc, ei, ep4, input logic ev);
      vec_t v;
      v.s = s; v.f = f; v.h = h; v.p = p; v.b = b; v.j = j; v.r = r;
      v.epc = epc; v.ei = ei; v.ep4 = ep4; v.ev = ev;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int idx, input logic [31:0] pc,
                          input logic [31:0] ins, input logic [31:0] p4, input logic v);
      chk({tag, "_addr"},  idx, Address, pc);
      chk({tag, "_instr"}, idx, IF_ID_Instruction, ins);
      chk({tag, "_pc4"},   idx, IF_ID_PCPlus4, p4);
      chk({tag, "_valid"}, idx, {31'h0, IF_ID_Valid}, {31'h0, v});
   endtask

   task automatic idle_inputs();
      Stall = 1'b0; Flush = 1'b0; Halt = 1'b0; PCSrc = 2'd0;
      BranchTarget = 32'hA00; JumpTarget = 32'hB00; JrTarget = 32'hC00;
   endtask

   localparam logic [31:0] DB = 32'hA00, DJ = 32'hB00, DR = 32'hC00;
   vec_t vt[21];

   initial begin
      vt[0]  = mk(0,0,0,2'd0, DB, DJ, DR, 32'h0, 32'h0, 32'h0, 0);
      vt[1]  = mk(0,0,0,2'd0, DB, DJ, DR, 32'h4, 32'h0, 32'h4, 1);
      vt[2]  = mk(0,0,0,2'd0, DB, DJ, DR, 32'h8, 32'h4, 32'h8, 1);
      vt[3]  = mk(0,0,0,2'd0, DB, DJ, DR, 32'hC, 32'h8, 32'hC, 1);
      vt[4]  = mk(0,0,0,2'd0, DB, DJ, DR, 32'h10, 32'hC, 32'h10, 1);
      vt[5]  = mk(1,0,0,2'd0, DB, DJ, DR, 32'h10, 32'hC, 32'h10, 1);
      vt[6]  = mk(1,0,0,2'd0, DB, DJ, DR, 32'h10, 32'hC, 32'h10, 1);
      vt[7]  = mk(1,0,0,2'd0, DB, DJ, DR, 32'h10, 32'hC, 32'h10, 1);
      vt[8]  = mk(0,0,0,2'd0, DB, DJ, DR, 32'h14, 32'h10, 32'h14, 1);
      vt[9]  = mk(1,1,0,2'd1, 32'h43, DJ, DR, 32'h40, 32'h0, 32'h0, 0);
      vt[10] = mk(0,0,0,2'd0, DB, DJ, DR, 32'h44, 32'h40, 32'h44, 1);
      vt[11] = mk(0,0,0,2'd2, DB, 32'h203, DR, 32'h200, 32'h44, 32'h48, 1);
      vt[12] = mk(1,0,0,2'd3, DB, DJ, 32'h1002, 32'h1000, 32'h44, 32'h48, 1);
      vt[13] = mk(0,1,0,2'd0, DB, DJ, DR, 32'h1004, 32'h0, 32'h0, 0);
      vt[14] = mk(0,0,0,2'd3, DB, DJ, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h1004, 32'h1008, 1);
      vt[15] = mk(0,0,0,2'd0, DB, DJ, DR, 32'h0, 32'hFFFFFFFC, 32'h0, 1);
      vt[16] = mk(0,0,0,2'd2, DB, 32'h20, DR, 32'h20, 32'h0, 32'h4, 1);
      vt[17] = mk(0,0,1,2'd0, DB, DJ, DR, 32'h20, 32'h0, 32'h0, 0);
      vt[18] = mk(0,0,0,2'd2, DB, 32'h100, DR, 32'h20, 32'h0, 32'h0, 0);
      vt[19] = mk(1,1,0,2'd1, 32'h80, DJ, DR, 32'h20, 32'h0, 32'h0, 0);
      vt[20] = mk(0,0,0,2'd0, DB, DJ, DR, 32'h20, 32'h0, 32'h0, 0);

      idle_inputs();
      Reset = 1'b0;
      #3 Reset = 1'b1;
      #1 chk_all("rst", 0, 32'h0, 32'h0, 32'h0, 0);
      @(negedge Clk);
      Reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         Stall = vt[i].s; Flush = vt[i].f; Halt = vt[i].h; PCSrc = vt[i].p;
         BranchTarget = vt[i].b; JumpTarget = vt[i].j; JrTarget = vt[i].r;
         @(posedge Clk);
         #1 chk_all("vec", i, vt[i].epc, vt[i].ei, vt[i].ep4, vt[i].ev);
         @(negedge Clk);
      end

      // async reset out of HALT with a redirect and halt still pending
      PCSrc = 2'd2; JumpTarget = 32'h300; Halt = 1'b1;
      Reset = 1'b1;
      #1 chk_all("hrst", 0, 32'h0, 32'h0, 32'h0, 0);
      @(posedge Clk);
      #1 chk_all("hrst", 1, 32'h0, 32'h0, 32'h0, 0);
      @(negedge Clk);
      Reset = 1'b0;
      @(posedge Clk);
      #1 chk_all("boot", 0, 32'h0, 32'h0, 32'h0, 0);
      @(negedge Clk);
      idle_inputs();
      @(posedge Clk);
      #1 chk_all("boot", 1, 32'h4, 32'h0, 32'h4, 1);
      @(posedge Clk);
      #1 chk_all("boot", 2, 32'h8, 32'h4, 32'h8, 1);

      // reset mid-cycle while a stalled jump is being presented
      @(negedge Clk);
      PCSrc = 2'd2; JumpTarget = 32'h300; Stall = 1'b1;
      #2 Reset = 1'b1;
      #1 chk_all("mrst", 0, 32'h0, 32'h0, 32'h0, 0);
      @(negedge Clk);
      idle_inputs();
      Reset = 1'b0;

`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt_rst", 0, FetchCount, 32'd0);
      chk("flush_cnt_rst", 0, FlushCount, 32'd0);
      @(posedge Clk);
      for (int i = 0; i < 5; i++) @(posedge Clk);
      @(negedge Clk);
      Flush = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      chk("fetch_cnt", 0, FetchCount, 32'd5);
      chk("flush_cnt", 0, FlushCount, 32'd2);
      @(negedge Clk);
      Flush = 1'b0;
      Reset = 1'b1;
      #1;
      chk("fetch_cnt_clr", 0, FetchCount, 32'd0);
      chk("flush_cnt_clr", 0, FlushCount, 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
